// File: rtl/nibble_serial_addsub_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_addsub_ctrl_if
//  Purpose  : Handshake/operand bundle for nibble_serial_addsub_ctrl.
//             master = front end that issues requests, slave = controller.
//  Signals  : start, op, a[W-1:0], b[W-1:0]       (master -> slave)
//             busy, done, result[W-1:0], cout      (slave -> master)
//             ovf                                  (slave -> master, only
//                                                   with ADDSUB_OVF_EN)
//  Macro    : ADDSUB_OVF_EN adds the ovf signal.
//  Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_addsub_ctrl_if #(
   parameter int NIBBLES = 4
);
   logic                   start;
   logic                   op;
   logic [4*NIBBLES-1:0]   a;
   logic [4*NIBBLES-1:0]   b;
   logic                   busy;
   logic                   done;
   logic [4*NIBBLES-1:0]   result;
   logic                   cout;
`ifdef ADDSUB_OVF_EN
   logic                   ovf;
`endif

   modport master (
      output start, op, a, b,
`ifdef ADDSUB_OVF_EN
      input  ovf,
`endif
      input  busy, done, result, cout
   );

   modport slave (
      input  start, op, a, b,
`ifdef ADDSUB_OVF_EN
      output ovf,
`endif
      output busy, done, result, cout
   );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_addsub_ctrl
//  Purpose  : Runs W-bit (W = 4*NIBBLES) add/subtract through a single 4-bit
//             add/sub slice, one nibble per clock, LS nibble first, with the
//             inter-nibble carry held in a register.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - slave modport: start/op/a/b in; busy/done/result/cout
//                      (and ovf) out
//  Params   : NIBBLES - operand width in nibbles, 2..16
//  Macro    : ADDSUB_OVF_EN - adds the registered signed-overflow output ovf
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   nibble_serial_addsub_ctrl_if.slave    bus
);

   localparam int c_width = 4 * NIBBLES;
   localparam int c_idx_w = $clog2(NIBBLES);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [c_width-1:0]     r_a;
   logic [c_width-1:0]     r_b;
   logic                   r_op;
   logic                   r_carry;
   logic [c_idx_w-1:0]     r_idx;
   logic [c_width-1:0]     r_result;
   logic                   r_cout;
   logic                   r_busy;
   logic                   r_done;
`ifdef ADDSUB_OVF_EN
   logic                   r_ovf;
`endif

   // Nibble slice datapath: A[i] + (op ? ~B[i] : B[i]) + carry
   logic [c_idx_w+1:0]     w_base;
   logic [3:0]             w_a_nib;
   logic [3:0]             w_b_nib;
   logic [4:0]             w_sum;
   logic                   w_last;

   assign w_base  = {r_idx, 2'b00};
   assign w_a_nib = r_a[w_base +: 4];
   assign w_b_nib = r_b[w_base +: 4] ^ {4{r_op}};
   assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
   assign w_last  = (r_idx == c_last_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 1'b0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef ADDSUB_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            // DONE accepts exactly like IDLE so operations can run back to back
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_op    <= bus.op;
                  r_carry <= bus.op;   // +1 of the two's complement on subtract
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_result[w_base +: 4] <= w_sum[3:0];
               r_carry               <= w_sum[4];
               if (w_last) begin
                  r_cout  <= w_sum[4];
`ifdef ADDSUB_OVF_EN
                  r_ovf   <= (w_a_nib[3] == w_b_nib[3]) && (w_sum[3] != w_a_nib[3]);
`endif
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.cout   = r_cout;
`ifdef ADDSUB_OVF_EN
   assign bus.ovf    = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/nibble_serial_addsub_ctrl.md
# nibble_serial_addsub_ctrl

Sequencing controller that runs multi-word addition and subtraction on one 4-bit add/sub slice. It processes one nibble per clock, least significant nibble first, and carries between nibbles through a register. It accepts operands of NIBBLES×4 bits with a start/busy/done handshake and presents the full result, carry-out and optional signed overflow. It sits between a register-file or test-driver front end and the team's 4-bit ripple add/sub datapath, giving wide arithmetic without widening the adder.

## Interface
- NIBBLES, default 4: operand width in nibbles (W = 4×NIBBLES). Legal range is 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse or level; sampled only when the block can accept.
- op  input  1  operation: 0 = add, 1 = subtract (A − B).
- a  input  W  operand A, captured on accept.
- b  input  W  operand B, captured on accept.
- busy  output  1  high while nibbles are being processed.
- done  output  1  single-cycle pulse when the result is valid.
- result  output  W  sum or difference; held until the next accept.
- cout  output  1  final carry. On subtract, 1 means no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow. Present only with ADDSUB_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start=1:
  - capture a, b and op into internal registers;
  - clear the nibble index to 0;
  - set the carry register to op (the +1 of two's complement on subtract).
- RUN, each cycle, with i = nibble index:
  - compute A[i] + (op ? ~B[i] : B[i]) + carry;
  - write the 4-bit sum into result nibble i;
  - load the carry register with the slice carry;
  - increment i.
- RUN → DONE after the cycle that processes i = NIBBLES−1. cout is the carry from that cycle.
- DONE lasts exactly one cycle with done=1, then returns to IDLE. Any start in DONE is accepted as in IDLE (DONE → RUN), which allows back-to-back operations.
- start during RUN is ignored, and operand inputs are not re-sampled.
- result, cout and ovf change only during RUN and on reset. They are stable from DONE until the next accept.
- Arithmetic is modulo 2^W; no saturation.
- The nibble index counter is ceil(log2(NIBBLES)) bits wide and never wraps past NIBBLES−1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state = IDLE, busy = 0, done = 0, result = 0, cout = 0, ovf = 0, carry = 0, index = 0.
- Accept edge = cycle 0. busy = 1 for cycles 1..NIBBLES. done = 1 in cycle NIBBLES+1, with busy = 0.
- Latency from accept to done is NIBBLES+1 cycles. Minimum initiation interval is NIBBLES+1 cycles.
- busy and done are registered outputs; neither is a combinational function of start.
- rst_n asserted mid-RUN aborts immediately: all outputs take their reset values, no done pulse follows, and the partial result is discarded.

## Configuration
- ADDSUB_OVF_EN defined:
  - ovf port exists;
  - on the last RUN cycle, ovf is set to (A_msb == B'_msb) && (S_msb != A_msb), where B' is the possibly-inverted B;
  - ovf is held with result.
- ADDSUB_OVF_EN undefined: the ovf port and its logic are absent; everything else is identical.

## Test plan
All scenarios use NIBBLES=4.
- Add: a=0x1234, b=0x0FFF, op=0, start at cycle 0 → busy cycles 1–4; done at cycle 5 with result=0x2233, cout=0.
- Subtract with borrow: a=0x0000, b=0x0001, op=1 → result=0xFFFF, cout=0. With a=0x0005, b=0x0003 → result=0x0002, cout=1.
- Wrap and overflow: a=0xFFFF + b=0x0001 → result=0x0000, cout=1, ovf=0. a=0x7FFF + b=0x0001 → result=0x8000, cout=0, ovf=1 (macro on).
- Busy protection: start held high for 10 cycles with a=0x0001, b=0x0001. Inputs change to 0x00FF at cycle 2 → first done at cycle 5 with result 0x0002. Second accept in DONE cycle 5, computing 0x00FF+0x00FF, gives done at cycle 10 with result=0x01FE.
- Reset mid-operation: rst_n low at cycle 2 of a RUN → outputs 0 immediately and no done pulse. After release, a new start completes correctly in 5 cycles.
- Macro off: build without ADDSUB_OVF_EN and rerun the scenarios above → identical result, cout, busy and done behaviour.
